// File: rtl/axi_rr_arbiter_if.sv
// Address-channel arbitration bundle between the crossbar decode/response logic
// and the per-slave round-robin arbiter.
interface axi_rr_arbiter_if #(
  parameter int NUM_M     = 3,
  parameter int NUM_S     = 6,
  parameter int MIDX_BITS = 3,
  parameter int SIDX_BITS = 2
);
  localparam int RR_BITS = $clog2(2 * NUM_M);

  // A slave connection is granted while REQ and the matching address READY are
  // both high; a read is held until the RVALID & RREADY & RLAST beat, a write
  // until the BVALID & BREADY beat, and it releases on that same cycle.
  logic [NUM_S:0][NUM_M-1:0]     R_REQ;
  logic [NUM_S:0][NUM_M-1:0]     W_REQ;
  logic [NUM_S:0]                ARREADY_S;
  logic [NUM_S:0]                AWREADY_S;
  logic [NUM_M-1:0]              RREADY_M;
  logic [NUM_M-1:0]              BREADY_M;
  logic [NUM_S:0]                RVALID_S;
  logic [NUM_S:0]                RLAST_S;
  logic [NUM_S:0]                BVALID_S;
  logic [NUM_S:0][SIDX_BITS-1:0] SRIdx;
  logic [NUM_S:0][SIDX_BITS-1:0] SWIdx;
  logic [NUM_M-1:0][MIDX_BITS-1:0] MRIdx;
  logic [NUM_M-1:0][MIDX_BITS-1:0] MWIdx;
  logic [NUM_S:0]                SBusy;
  // Debug view: rr pointer and connection state (0 idle, 1 read, 2 write).
  logic [NUM_S:0][RR_BITS-1:0]   dbg_rr;
  logic [NUM_S:0][1:0]           dbg_state;

  modport master (
    output R_REQ, W_REQ, ARREADY_S, AWREADY_S, RREADY_M, BREADY_M,
           RVALID_S, RLAST_S, BVALID_S,
    input  SRIdx, SWIdx, MRIdx, MWIdx, SBusy, dbg_rr, dbg_state
  );

  modport slave (
    input  R_REQ, W_REQ, ARREADY_S, AWREADY_S, RREADY_M, BREADY_M,
           RVALID_S, RLAST_S, BVALID_S,
    output SRIdx, SWIdx, MRIdx, MWIdx, SBusy, dbg_rr, dbg_state
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// Per-slave AXI address arbiter: round-robin over 2*NUM_M read/write requesters,
// one held connection per slave, no master direction granted to two slaves.
module axi_rr_arbiter #(
  parameter int NUM_M     = 3,
  parameter int NUM_S     = 6,
  parameter int MIDX_BITS = 3,
  parameter int SIDX_BITS = 2
) (
  input logic           clk,
  input logic           rst,
  axi_rr_arbiter_if.slave bus
);
  localparam int NK  = 2 * NUM_M;
  localparam int KB  = $clog2(NK);
  localparam int MB  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int NSL = NUM_S + 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} conn_st_t;

  conn_st_t        st     [NSL];
  logic [MB-1:0]   conn_m [NSL];
  logic [KB-1:0]   rr     [NSL];
  logic [NUM_S:0]  sbusy_q;

  logic [NUM_M-1:0] held_r, held_w, taken_r, taken_w;
  logic [NUM_S:0]   rel, win_vld, win_w;
  logic [MB-1:0]    win_m [NSL];
  logic [KB-1:0]    win_k [NSL];
  logic [NK-1:0]    elig;
  logic [2*NK-1:0]  rot;
  int               kk;

  // Slaves resolve in index order; a releasing connection still counts as held.
  always_comb begin
    held_r  = '0;
    held_w  = '0;
    taken_r = '0;
    taken_w = '0;
    elig    = '0;
    rot     = '0;
    kk      = 0;
    rel     = '0;
    win_vld = '0;
    win_w   = '0;
    for (int s = 0; s < NSL; s++) begin
      win_m[s] = '0;
      win_k[s] = '0;
      if (st[s] == ST_RD) held_r[conn_m[s]] = 1'b1;
      if (st[s] == ST_WR) held_w[conn_m[s]] = 1'b1;
    end
    for (int s = 0; s < NSL; s++) begin
      rel[s] = (st[s] == ST_IDLE) ||
               (st[s] == ST_RD && bus.RVALID_S[s] && bus.RLAST_S[s] && bus.RREADY_M[conn_m[s]]) ||
               (st[s] == ST_WR && bus.BVALID_S[s] && bus.BREADY_M[conn_m[s]]);
      for (int m = 0; m < NUM_M; m++) begin
        elig[m]         = bus.R_REQ[s][m] & bus.ARREADY_S[s] & ~held_r[m] & ~taken_r[m];
        elig[NUM_M + m] = bus.W_REQ[s][m] & bus.AWREADY_S[s] & ~held_w[m] & ~taken_w[m];
      end
      rot = {elig, elig} >> rr[s];
      kk  = 0;
      // Descending scan so the last hit is the one closest to rr[s].
      for (int i = NK - 1; i >= 0; i--) begin
        if (rot[i]) begin
          win_vld[s] = 1'b1;
          kk = (int'(rr[s]) + i) % NK;
        end
      end
      if (win_vld[s]) begin
        win_k[s] = KB'(kk);
        win_w[s] = (kk >= NUM_M);
        win_m[s] = MB'((kk >= NUM_M) ? kk - NUM_M : kk);
        if (rel[s]) begin
          if (win_w[s]) taken_w[win_m[s]] = 1'b1;
          else          taken_r[win_m[s]] = 1'b1;
        end
      end
    end
  end

  conn_st_t      eff_st;
  logic [MB-1:0] eff_m;

  always_comb begin
    bus.SRIdx = '0;
    bus.SWIdx = '0;
    bus.MRIdx = '0;
    bus.MWIdx = '0;
    eff_st    = ST_IDLE;
    eff_m     = '0;
    for (int s = 0; s < NSL; s++) begin
      eff_st = st[s];
      eff_m  = conn_m[s];
      if (st[s] == ST_IDLE && win_vld[s]) begin
        eff_st = win_w[s] ? ST_WR : ST_RD;
        eff_m  = win_m[s];
      end
      if (eff_st == ST_RD) begin
        bus.SRIdx[s]     = SIDX_BITS'(eff_m) + SIDX_BITS'(1);
        bus.MRIdx[eff_m] = MIDX_BITS'(s + 1);
      end else if (eff_st == ST_WR) begin
        bus.SWIdx[s]     = SIDX_BITS'(eff_m) + SIDX_BITS'(1);
        bus.MWIdx[eff_m] = MIDX_BITS'(s + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSL; s++) begin
        st[s]     <= ST_IDLE;
        conn_m[s] <= '0;
        rr[s]     <= '0;
      end
      sbusy_q <= '0;
    end else begin
      for (int s = 0; s < NSL; s++) begin
        if (rel[s]) begin
          if (win_vld[s]) begin
            st[s]      <= win_w[s] ? ST_WR : ST_RD;
            conn_m[s]  <= win_m[s];
            rr[s]      <= KB'((int'(win_k[s]) + 1) % NK);
            sbusy_q[s] <= 1'b1;
          end else begin
            st[s]      <= ST_IDLE;
            sbusy_q[s] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    bus.SBusy     = sbusy_q;
    bus.dbg_rr    = '0;
    bus.dbg_state = '0;
    for (int s = 0; s < NSL; s++) begin
      bus.dbg_rr[s]    = rr[s];
      bus.dbg_state[s] = st[s];
    end
  end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: requester-level model checked every cycle, plus
// directed scenarios with hand-computed index values.
module tb_axi_rr_arbiter;
  localparam int NUM_M     = 3;
  localparam int NUM_S     = 6;
  localparam int MIDX_BITS = 3;
  localparam int SIDX_BITS = 2;
  localparam int RR_BITS   = 3;
  localparam int NK        = 2 * NUM_M;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_rr_arbiter_if #(.NUM_M(NUM_M), .NUM_S(NUM_S), .MIDX_BITS(MIDX_BITS), .SIDX_BITS(SIDX_BITS)) bus ();

  axi_rr_arbiter #(.NUM_M(NUM_M), .NUM_S(NUM_S), .MIDX_BITS(MIDX_BITS), .SIDX_BITS(SIDX_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner per slave: kind 0 none, 1 read, 2 write; plus owning master and pointer.
  int m_kind [NUM_S+1];
  int m_mst  [NUM_S+1];
  int m_rr   [NUM_S+1];
  int n_kind [NUM_S+1];
  int n_mst  [NUM_S+1];
  int n_rr   [NUM_S+1];
  bit busy_r [NUM_M];
  bit busy_w [NUM_M];
  int win, k, mm, ek, em;
  bit want, rls;
  logic [NUM_S:0][SIDX_BITS-1:0]   e_sr, e_sw;
  logic [NUM_M-1:0][MIDX_BITS-1:0] e_mr, e_mw;
  logic [NUM_S:0]                  e_busy;
  logic [NUM_S:0][RR_BITS-1:0]     e_rr;

  always @(negedge clk) begin
    for (int m = 0; m < NUM_M; m++) begin
      busy_r[m] = 1'b0;
      busy_w[m] = 1'b0;
    end
    for (int s = 0; s <= NUM_S; s++) begin
      if (m_kind[s] == 1) busy_r[m_mst[s]] = 1'b1;
      if (m_kind[s] == 2) busy_w[m_mst[s]] = 1'b1;
    end
    e_sr = '0; e_sw = '0; e_mr = '0; e_mw = '0; e_busy = '0; e_rr = '0;
    for (int s = 0; s <= NUM_S; s++) begin
      win = -1;
      for (int j = 0; j < NK; j++) begin
        k  = (m_rr[s] + j) % NK;
        mm = k % NUM_M;
        if (k < NUM_M) want = bus.R_REQ[s][mm] && bus.ARREADY_S[s] && !busy_r[mm];
        else           want = bus.W_REQ[s][mm] && bus.AWREADY_S[s] && !busy_w[mm];
        if (want && win < 0) win = k;
      end
      rls = (m_kind[s] == 0) ||
            (m_kind[s] == 1 && bus.RVALID_S[s] && bus.RLAST_S[s] && bus.RREADY_M[m_mst[s]]) ||
            (m_kind[s] == 2 && bus.BVALID_S[s] && bus.BREADY_M[m_mst[s]]);
      ek = m_kind[s];
      em = m_mst[s];
      if (ek == 0 && win >= 0) begin
        ek = (win < NUM_M) ? 1 : 2;
        em = win % NUM_M;
      end
      if (ek == 1) begin
        e_sr[s]  = SIDX_BITS'(em + 1);
        e_mr[em] = MIDX_BITS'(s + 1);
      end else if (ek == 2) begin
        e_sw[s]  = SIDX_BITS'(em + 1);
        e_mw[em] = MIDX_BITS'(s + 1);
      end
      e_busy[s] = (m_kind[s] != 0);
      e_rr[s]   = RR_BITS'(m_rr[s]);
      n_kind[s] = m_kind[s];
      n_mst[s]  = m_mst[s];
      n_rr[s]   = m_rr[s];
      if (rls) begin
        if (win >= 0) begin
          n_kind[s] = (win < NUM_M) ? 1 : 2;
          n_mst[s]  = win % NUM_M;
          n_rr[s]   = (win + 1) % NK;
          if (win < NUM_M) busy_r[win % NUM_M] = 1'b1;
          else             busy_w[win % NUM_M] = 1'b1;
        end else begin
          n_kind[s] = 0;
        end
      end
      if (rst) begin
        n_kind[s] = 0;
        n_mst[s]  = 0;
        n_rr[s]   = 0;
      end
    end
    if (!rst) begin
      chk("model_sridx", 64'(bus.SRIdx), 64'(e_sr));
      chk("model_swidx", 64'(bus.SWIdx), 64'(e_sw));
      chk("model_mridx", 64'(bus.MRIdx), 64'(e_mr));
      chk("model_mwidx", 64'(bus.MWIdx), 64'(e_mw));
      chk("model_sbusy", 64'(bus.SBusy), 64'(e_busy));
      chk("model_rr",    64'(bus.dbg_rr), 64'(e_rr));
    end
  end

  always @(posedge clk) begin
    m_kind <= n_kind;
    m_mst  <= n_mst;
    m_rr   <= n_rr;
  end

  // ---------------- driver tasks ----------------
  task automatic clr_in();
    bus.R_REQ     = '0;
    bus.W_REQ     = '0;
    bus.ARREADY_S = '0;
    bus.AWREADY_S = '0;
    bus.RREADY_M  = '0;
    bus.BREADY_M  = '0;
    bus.RVALID_S  = '0;
    bus.RLAST_S   = '0;
    bus.BVALID_S  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    clr_in();
    step();
    rst = 1'b0;
  endtask

  int seq_sr1 [5] = '{1, 1, 2, 3, 1};
  int seq_sr2 [4] = '{1, 1, 0, 1};
  int seq_sw2 [4] = '{0, 0, 1, 0};

  initial begin
    clr_in();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    neg();
    chk("reset_sbusy", 64'(bus.SBusy), 64'd0);
    chk("reset_sridx", 64'(bus.SRIdx), 64'd0);
    chk("reset_mwidx", 64'(bus.MWIdx), 64'd0);
    chk("reset_rr",    64'(bus.dbg_rr), 64'd0);

    // Round-robin of three masters on slave 2, one-beat bursts.
    step();
    bus.R_REQ[2] = 3'b111;
    bus.ARREADY_S[2] = 1'b1;
    bus.RVALID_S[2] = 1'b1;
    bus.RLAST_S[2] = 1'b1;
    bus.RREADY_M = 3'b111;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("rr_sridx2", 64'(bus.SRIdx[2]), 64'(seq_sr1[i]));
      chk("rr_mridx", 64'(bus.MRIdx[seq_sr1[i] - 1]), 64'd3);
      if (i == 1) chk("rr_sbusy2", 64'(bus.SBusy[2]), 64'd1);
      step();
    end
    do_reset();

    // Read/write alternation of master 0 on slave 1.
    bus.R_REQ[1] = 3'b001;
    bus.W_REQ[1] = 3'b001;
    bus.ARREADY_S[1] = 1'b1;
    bus.AWREADY_S[1] = 1'b1;
    bus.RVALID_S[1] = 1'b1;
    bus.RLAST_S[1] = 1'b1;
    bus.BVALID_S[1] = 1'b1;
    bus.RREADY_M = 3'b111;
    bus.BREADY_M = 3'b111;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("alt_sridx1", 64'(bus.SRIdx[1]), 64'(seq_sr2[i]));
      chk("alt_swidx1", 64'(bus.SWIdx[1]), 64'(seq_sw2[i]));
      if (i == 2) chk("alt_mwidx0", 64'(bus.MWIdx[0]), 64'd2);
      step();
    end
    do_reset();

    // Master 0 busy on slave 1 for a 4-beat read blocks its read on slave 3.
    bus.R_REQ[1][0] = 1'b1;
    bus.R_REQ[3][0] = 1'b1;
    bus.ARREADY_S[1] = 1'b1;
    bus.ARREADY_S[3] = 1'b1;
    bus.RREADY_M = 3'b111;
    neg();
    chk("excl_sridx1", 64'(bus.SRIdx[1]), 64'd1);
    chk("excl_sridx3", 64'(bus.SRIdx[3]), 64'd0);
    step();
    bus.R_REQ[1] = '0;
    bus.RVALID_S[1] = 1'b1;
    for (int beat = 1; beat <= 4; beat++) begin
      if (beat == 4) bus.RLAST_S[1] = 1'b1;
      neg();
      chk("burst_sridx3", 64'(bus.SRIdx[3]), 64'd0);
      chk("burst_sridx1", 64'(bus.SRIdx[1]), 64'd1);
      step();
    end
    bus.RVALID_S[1] = 1'b0;
    bus.RLAST_S[1] = 1'b0;
    neg();
    chk("after_sridx3", 64'(bus.SRIdx[3]), 64'd1);
    chk("after_mridx0", 64'(bus.MRIdx[0]), 64'd4);
    do_reset();

    // Same-cycle requests of master 1 to slaves 0 and 4: lower slave wins.
    bus.R_REQ[0][1] = 1'b1;
    bus.R_REQ[4][1] = 1'b1;
    bus.ARREADY_S[0] = 1'b1;
    bus.ARREADY_S[4] = 1'b1;
    bus.RREADY_M = 3'b111;
    neg();
    chk("dual_mridx1", 64'(bus.MRIdx[1]), 64'd1);
    chk("dual_sridx0", 64'(bus.SRIdx[0]), 64'd2);
    chk("dual_sridx4", 64'(bus.SRIdx[4]), 64'd0);
    step();
    bus.R_REQ[0] = '0;
    bus.RVALID_S[0] = 1'b1;
    bus.RLAST_S[0] = 1'b1;
    neg();
    chk("dual_rel_sridx4", 64'(bus.SRIdx[4]), 64'd0);
    step();
    bus.RVALID_S[0] = 1'b0;
    bus.RLAST_S[0] = 1'b0;
    neg();
    chk("dual_late_sridx4", 64'(bus.SRIdx[4]), 64'd2);
    chk("dual_late_mridx1", 64'(bus.MRIdx[1]), 64'd5);
    do_reset();

    // Write held by BREADY low, then back-to-back handover to a read.
    bus.W_REQ[5][2] = 1'b1;
    bus.AWREADY_S[5] = 1'b1;
    neg();
    chk("wr_swidx5", 64'(bus.SWIdx[5]), 64'd3);
    chk("wr_mwidx2", 64'(bus.MWIdx[2]), 64'd6);
    step();
    bus.W_REQ[5] = '0;
    bus.BVALID_S[5] = 1'b1;
    bus.R_REQ[5][0] = 1'b1;
    bus.ARREADY_S[5] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("hold_swidx5", 64'(bus.SWIdx[5]), 64'd3);
      chk("hold_sridx5", 64'(bus.SRIdx[5]), 64'd0);
      step();
    end
    bus.BREADY_M[2] = 1'b1;
    neg();
    chk("release_swidx5", 64'(bus.SWIdx[5]), 64'd3);
    step();
    bus.BREADY_M = '0;
    bus.BVALID_S[5] = 1'b0;
    neg();
    chk("handover_sridx5", 64'(bus.SRIdx[5]), 64'd1);
    chk("handover_swidx5", 64'(bus.SWIdx[5]), 64'd0);
    chk("handover_sbusy5", 64'(bus.SBusy[5]), 64'd1);
    do_reset();

    // Reset pulse mid-burst, plus a request to a slave whose READY is low.
    bus.R_REQ[2][1] = 1'b1;
    bus.ARREADY_S[2] = 1'b1;
    bus.RREADY_M = 3'b111;
    neg();
    chk("rst_grant_sridx2", 64'(bus.SRIdx[2]), 64'd2);
    step();
    bus.R_REQ[2] = '0;
    bus.RVALID_S[2] = 1'b1;
    neg();
    chk("rst_pre_sbusy2", 64'(bus.SBusy[2]), 64'd1);
    chk("rst_pre_rr2", 64'(bus.dbg_rr[2]), 64'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    neg();
    chk("rst_post_sbusy", 64'(bus.SBusy), 64'd0);
    chk("rst_post_sridx", 64'(bus.SRIdx), 64'd0);
    chk("rst_post_mridx", 64'(bus.MRIdx), 64'd0);
    chk("rst_post_rr", 64'(bus.dbg_rr), 64'd0);
    step();
    bus.RVALID_S[2] = 1'b0;
    bus.R_REQ[2] = 3'b111;
    bus.R_REQ[3][2] = 1'b1;
    bus.ARREADY_S[3] = 1'b0;
    neg();
    chk("rst_restart_sridx2", 64'(bus.SRIdx[2]), 64'd1);
    chk("notready_sridx3", 64'(bus.SRIdx[3]), 64'd0);
    do_reset();

    // Mixed traffic soak checked by the model alone.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s <= NUM_S; s++) begin
        bus.R_REQ[s]     = NUM_M'($urandom_range(0, 7)) & NUM_M'($urandom_range(0, 7));
        bus.W_REQ[s]     = NUM_M'($urandom_range(0, 7)) & NUM_M'($urandom_range(0, 7));
        bus.ARREADY_S[s] = ($urandom_range(0, 3) != 0);
        bus.AWREADY_S[s] = ($urandom_range(0, 3) != 0);
        bus.RVALID_S[s]  = ($urandom_range(0, 1) != 0);
        bus.RLAST_S[s]   = ($urandom_range(0, 1) != 0);
        bus.BVALID_S[s]  = ($urandom_range(0, 1) != 0);
      end
      for (int m = 0; m < NUM_M; m++) begin
        bus.RREADY_M[m] = ($urandom_range(0, 3) != 0);
        bus.BREADY_M[m] = ($urandom_range(0, 3) != 0);
      end
      if (c == 200) rst = 1'b1;
      if (c == 201) rst = 1'b0;
      step();
    end
    clr_in();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
